// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the debug command scheduler and the dbg_guv command decode.
package dbg_cmd_pkg;

    // Command word width carried on the dbg_guv cmd_in stream.
    localparam int CMD_WIDTH = 32;

    // Command word field layout, shared with the dbg_guv decoder.
    localparam int CMD_OP_LSB  = 0;
    localparam int CMD_OP_W    = 8;
    localparam int CMD_ARG_LSB = 8;
    localparam int CMD_ARG_W   = 24;

    // Scheduler states: IDLE arbitrates, LOCK forwards one requester's packet.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } sched_state_t;

endpackage

// File: rtl/dbg_cmd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index after the
// previously granted one, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_idx_i,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic [IDX_W-1:0] cand_idx;

    // Scan from last_idx+1 upward (modulo NUM_REQ); the first hit wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand_idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_idx = IDX_W'((int'(last_idx_i) + off) % NUM_REQ);
            if (!gnt_valid_o && req_i[cand_idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dbg_cmd_sched.sv
// Command scheduler: merges NUM_REQ requester command streams onto a single
// registered cmd_out stream with round-robin arbitration, TLAST packet lock,
// a minimum inter-command gap and a stalled-requester timeout.
module dbg_cmd_sched
    import dbg_cmd_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CMD_WIDTH  = dbg_cmd_pkg::CMD_WIDTH,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_TDATA,
    input  logic [NUM_REQ-1:0]             req_TLAST,
    input  logic [NUM_REQ-1:0]             req_TVALID,
    output logic [NUM_REQ-1:0]             req_TREADY,
    output logic [CMD_WIDTH-1:0]           cmd_out_TDATA,
    output logic                           cmd_out_TLAST,
    output logic                           cmd_out_TVALID,
    input  logic                           cmd_out_TREADY,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           err_timeout,
    output logic [CNT_WIDTH-1:0]           issued_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    sched_state_t           state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic                   out_v_q;
    logic [CMD_WIDTH-1:0]   out_data_q;
    logic                   out_last_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [GAP_W-1:0]       gap_cnt_d;
    logic [TO_W-1:0]        to_cnt_q;
    logic [CNT_WIDTH-1:0]   issued_cnt_q;
    logic [CNT_WIDTH-1:0]   issued_cnt_d;
    logic                   err_timeout_q;

    logic [CMD_WIDTH-1:0]   req_word [NUM_REQ];
    logic                   arb_valid;
    logic [IDX_W-1:0]       arb_idx;
    logic                   lock_ready;
    logic                   accept;
    logic                   stall;
    logic                   out_hs;

    // Unpack the flat requester bus and steer TREADY to the granted requester only.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi]   = req_TDATA[gi*CMD_WIDTH +: CMD_WIDTH];
            assign req_TREADY[gi] = lock_ready && (grant_q == IDX_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i       (req_TVALID),
        .last_idx_i  (rr_ptr_q),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    // Ready depends only on registered state so TREADY never waits on TVALID.
    assign lock_ready = (state_q == LOCK) && !out_v_q && (gap_cnt_q == '0);
    assign accept     = lock_ready && req_TVALID[grant_q];
    assign stall      = lock_ready && !req_TVALID[grant_q];
    assign out_hs     = out_v_q && cmd_out_TREADY;

    // Gap reload on every output handshake, saturating issued-command count.
    always_comb begin
        gap_cnt_d    = gap_cnt_q;
        issued_cnt_d = issued_cnt_q;
        if (out_hs) begin
            gap_cnt_d = GAP_W'(GAP_CYCLES);
            if (issued_cnt_q != '1) begin
                issued_cnt_d = issued_cnt_q + CNT_WIDTH'(1);
            end
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
    end

    // Scheduler FSM with output register, timeout counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            out_v_q       <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
            issued_cnt_q  <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= 1'b0;
            gap_cnt_q     <= gap_cnt_d;
            issued_cnt_q  <= issued_cnt_d;

            // Accept and handshake are mutually exclusive (accept needs out_v == 0).
            if (accept) begin
                out_v_q <= 1'b1;
            end else if (out_hs) begin
                out_v_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q  <= arb_idx;
                        to_cnt_q <= '0;
                        state_q  <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        out_data_q <= req_word[grant_q];
                        out_last_q <= req_TLAST[grant_q];
                        to_cnt_q   <= '0;
                        if (req_TLAST[grant_q]) begin
                            rr_ptr_q <= grant_q;
                            state_q  <= IDLE;
                        end
                    end else if (stall) begin
                        // Only genuine requester stalls count; gap/out-full waits do not.
                        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                            to_cnt_q      <= '0;
                            err_timeout_q <= 1'b1;
                            rr_ptr_q      <= grant_q;
                            state_q       <= IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_out_TDATA  = out_data_q;
    assign cmd_out_TLAST  = out_last_q;
    assign cmd_out_TVALID = out_v_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != IDLE) || out_v_q;
    assign err_timeout    = err_timeout_q;
    assign issued_cnt     = issued_cnt_q;

endmodule

// File: tb/tb_dbg_cmd_sched.sv
// Scoreboard bench for dbg_cmd_sched: requester words come from per-requester
// source queues, expected cmd_out words are queued in predicted arbitration order.
module tb_dbg_cmd_sched;

    localparam int NUM_REQ = 4;
    localparam int CW      = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ*CW-1:0]   req_TDATA;
    logic [NUM_REQ-1:0]      req_TLAST;
    logic [NUM_REQ-1:0]      req_TVALID;
    logic [NUM_REQ-1:0]      req_TREADY;
    logic [CW-1:0]           cmd_out_TDATA;
    logic                    cmd_out_TLAST;
    logic                    cmd_out_TVALID;
    logic                    cmd_out_TREADY;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    err_timeout;
    logic [15:0]             issued_cnt;

    always #5 clk = ~clk;

    dbg_cmd_sched #(
        .NUM_REQ    (NUM_REQ),
        .CMD_WIDTH  (CW),
        .GAP_CYCLES (4),
        .TIMEOUT    (256),
        .CNT_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_TDATA      (req_TDATA),
        .req_TLAST      (req_TLAST),
        .req_TVALID     (req_TVALID),
        .req_TREADY     (req_TREADY),
        .cmd_out_TDATA  (cmd_out_TDATA),
        .cmd_out_TLAST  (cmd_out_TLAST),
        .cmd_out_TVALID (cmd_out_TVALID),
        .cmd_out_TREADY (cmd_out_TREADY),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .issued_cnt     (issued_cnt)
    );

    logic [32:0] src_q [NUM_REQ][$];
    logic [32:0] sb [$];
    bit          hs_in [NUM_REQ];
    bit          hs_out;
    logic [32:0] hs_word;
    bit          ordy;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_src(input int r, input logic last, input logic [31:0] data);
        src_q[r].push_back({last, data});
    endtask

    task automatic push_exp(input logic last, input logic [31:0] data);
        sb.push_back({last, data});
    endtask

    // One clock: retire handshakes from the edge just passed, then drive the next cycle.
    task automatic tick();
        logic [32:0] w;
        logic [32:0] exp;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_in[i] && src_q[i].size() > 0) w = src_q[i].pop_front();
        end
        if (hs_out) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 33'h1_dead_beef;
            check_val("cmd_out_word", 64'(hs_word), 64'(exp));
            $display("cmd_out word 0x%08h last=%0b issued_cnt=%0d", hs_word[31:0], hs_word[32], issued_cnt);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                w = src_q[i][0];
                req_TDATA[i*CW +: CW] = w[31:0];
                req_TLAST[i]          = w[32];
                req_TVALID[i]         = 1'b1;
            end else begin
                req_TDATA[i*CW +: CW] = '0;
                req_TLAST[i]          = 1'b0;
                req_TVALID[i]         = 1'b0;
            end
        end
        cmd_out_TREADY = ordy;
        #1;
        for (int i = 0; i < NUM_REQ; i++) hs_in[i] = req_TVALID[i] && req_TREADY[i];
        hs_out  = cmd_out_TVALID && cmd_out_TREADY;
        hs_word = {cmd_out_TLAST, cmd_out_TDATA};
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((sb.size() > 0 || cmd_out_TVALID || hs_out) && n < bound) begin
            tick();
            n++;
        end
        check_val("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_val({pfx, "_tvalid"}, 64'(cmd_out_TVALID), 64'd0);
        check_val({pfx, "_tdata"},  64'(cmd_out_TDATA),  64'd0);
        check_val({pfx, "_tlast"},  64'(cmd_out_TLAST),  64'd0);
        check_val({pfx, "_tready"}, 64'(req_TREADY),     64'd0);
        check_val({pfx, "_grant"},  64'(grant_id),       64'd0);
        check_val({pfx, "_busy"},   64'(busy),           64'd0);
        check_val({pfx, "_err"},    64'(err_timeout),    64'd0);
        check_val({pfx, "_issued"}, 64'(issued_cnt),     64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            hs_in[i] = 1'b0;
        end
        sb.delete();
        hs_out     = 1'b0;
        req_TDATA  = '0;
        req_TLAST  = '0;
        req_TVALID = '0;
        ordy       = 1'b1;
        cmd_out_TREADY = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        int n, t0, t_hs, stall;

        // ---- 1: single word latency and inter-command gap ----
        do_reset();
        push_src(0, 1'b1, 32'h0000_0201); push_exp(1'b1, 32'h0000_0201);
        push_src(0, 1'b1, 32'h0000_0202); push_exp(1'b1, 32'h0000_0202);
        tick();
        t0 = cyc;
        n = 0;
        while (!cmd_out_TVALID && n < 20) begin tick(); n++; end
        check_val("t1_latency", 64'(cyc - t0), 64'd2);
        check_val("t1_handshake", 64'(hs_out), 64'd1);
        t_hs = cyc;
        n = 0;
        while (!req_TREADY[0] && n < 20) begin tick(); n++; end
        check_val("t1_gap", 64'(cyc - t_hs), 64'd5);
        drain(50);
        check_val("t1_issued", 64'(issued_cnt), 64'd2);

        // ---- 2: all requesters valid, round-robin order 0,1,2,3,0,... ----
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                push_src(r, 1'b1, 32'((r << 8) | k));
                push_exp(1'b1, 32'((r << 8) | k));
            end
        end
        drain(300);
        check_val("t2_issued", 64'(issued_cnt), 64'd8);

        // ---- 3: multi-word packet is not interleaved ----
        check_val("t3_idle_busy", 64'(busy), 64'd0);
        push_src(1, 1'b0, 32'h11); push_src(1, 1'b0, 32'h12); push_src(1, 1'b1, 32'h13);
        push_src(2, 1'b1, 32'h21);
        push_exp(1'b0, 32'h11); push_exp(1'b0, 32'h12); push_exp(1'b1, 32'h13);
        push_exp(1'b1, 32'h21);
        drain(200);
        check_val("t3_issued", 64'(issued_cnt), 64'd12);

        // ---- 4: cmd_out back-pressure keeps word stable ----
        ordy = 1'b0;
        push_src(0, 1'b1, 32'h41); push_src(0, 1'b1, 32'h42);
        push_exp(1'b1, 32'h41);    push_exp(1'b1, 32'h42);
        n = 0;
        while (!cmd_out_TVALID && n < 20) begin tick(); n++; end
        for (int k = 0; k < 20; k++) begin
            tick();
            check_val("t4_tvalid_hold", 64'(cmd_out_TVALID), 64'd1);
            check_val("t4_tdata_hold",  64'(cmd_out_TDATA),  64'h41);
            check_val("t4_no_tready",   64'(req_TREADY),     64'd0);
        end
        check_val("t4_issued_stalled", 64'(issued_cnt), 64'd12);
        ordy = 1'b1;
        drain(100);
        check_val("t4_issued", 64'(issued_cnt), 64'd14);

        // ---- 5: locked requester stalls mid-packet, timeout releases ----
        push_src(3, 1'b0, 32'h31); push_exp(1'b0, 32'h31);
        push_src(0, 1'b1, 32'h01); push_exp(1'b1, 32'h01);
        stall = 0;
        n = 0;
        while (!err_timeout && n < 600) begin
            tick();
            if (req_TREADY[3] && !req_TVALID[3]) stall++;
            n++;
        end
        check_val("t5_err_pulse", 64'(err_timeout), 64'd1);
        check_val("t5_stall_cycles", 64'(stall), 64'd256);
        check_val("t5_grant_hold", 64'(grant_id), 64'd3);
        check_val("t5_busy_idle", 64'(busy), 64'd0);
        tick();
        check_val("t5_err_one_cycle", 64'(err_timeout), 64'd0);
        check_val("t5_next_grant", 64'(grant_id), 64'd0);
        drain(100);

        // ---- 6: asynchronous reset mid-packet ----
        ordy = 1'b0;
        push_src(1, 1'b0, 32'h61); push_src(1, 1'b0, 32'h62); push_src(1, 1'b1, 32'h63);
        n = 0;
        while (!cmd_out_TVALID && n < 20) begin tick(); n++; end
        check_val("t6_pre_tvalid", 64'(cmd_out_TVALID), 64'd1);
        tick();
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_async");
        do_reset();
        push_src(2, 1'b1, 32'h72); push_src(0, 1'b1, 32'h70);
        push_exp(1'b1, 32'h70);    push_exp(1'b1, 32'h72);
        drain(100);
        check_val("t6_issued", 64'(issued_cnt), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
